// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: destination-select encodings, field widths and
// the packed pipeline-register layout.
package id_ex_stage_pkg;

    localparam int unsigned ALUOP_W    = 4;
    localparam int unsigned MEMTOREG_W = 2;
    localparam int unsigned REG_W      = 5;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        RD_RT   = 2'd0,
        RD_RD   = 2'd1,
        RD_RA   = 2'd2,
        RD_ZERO = 2'd3
    } regdst_e;

    typedef struct packed {
        logic [31:0]           pc_add4;
        logic [31:0]           inst;
        logic [31:0]           rs_data;
        logic [31:0]           rt_data;
        logic [31:0]           imm_ext;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic [MEMTOREG_W-1:0] mem_to_reg;
        logic [1:0]            reg_dst;
        logic [ALUOP_W-1:0]    alu_op;
        logic [REG_W-1:0]      write_reg;
    } id_ex_t;

    // Destination register selected by the RegDst control.
    function automatic logic [REG_W-1:0] dest_reg(
        input regdst_e          sel,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd
    );
        case (sel)
            RD_RT:   return rt;
            RD_RD:   return rd;
            RD_RA:   return REG_RA;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             mem_read,
    input  logic [REG_W-1:0] write_reg,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             flush,
    output logic             stall
);

    // Stall when a real load targets a source of the ID instruction; a flushed load is harmless.
    always_comb begin
        stall = 1'b0;
        if (!flush && mem_read && (write_reg != '0) &&
            ((write_reg == rs) || (write_reg == rt)))
            stall = 1'b1;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold, load-use bubble insertion and a
// saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter logic [15:0] BUBBLE_MAX = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           IPCAdd4,
    input  logic [31:0]           IInst,
    input  logic [31:0]           IRsData,
    input  logic [31:0]           IRtData,
    input  logic [31:0]           IImmExt,
    input  logic                  IRegWrite,
    input  logic                  IMemRead,
    input  logic                  IMemWrite,
    input  logic                  IALUSrc,
    input  logic [MEMTOREG_W-1:0] IMemToReg,
    input  logic [1:0]            IRegDst,
    input  logic [ALUOP_W-1:0]    IALUOp,
    input  logic                  CFlush,
    input  logic                  CHold,
    output logic [31:0]           OPCAdd4,
    output logic [31:0]           OInst,
    output logic [31:0]           ORsData,
    output logic [31:0]           ORtData,
    output logic [31:0]           OImmExt,
    output logic                  ORegWrite,
    output logic                  OMemRead,
    output logic                  OMemWrite,
    output logic                  OALUSrc,
    output logic [MEMTOREG_W-1:0] OMemToReg,
    output logic [1:0]            ORegDst,
    output logic [ALUOP_W-1:0]    OALUOp,
    output logic [REG_W-1:0]      OWriteReg,
    output logic                  OStall,
    output logic [15:0]           OBubbleCnt
);

    id_ex_t r;
    id_ex_t capture;
    logic   bubble;

    hazard_detect u_hazard_detect (
        .mem_read  (r.mem_read),
        .write_reg (r.write_reg),
        .rs        (IInst[25:21]),
        .rt        (IInst[20:16]),
        .flush     (CFlush),
        .stall     (OStall)
    );

    // Stall only inserts a bubble when neither flush nor hold takes priority.
    assign bubble = OStall && !CHold;

    // Assemble the incoming ID fields, resolving the destination register now.
    always_comb begin
        capture            = '0;
        capture.pc_add4    = IPCAdd4;
        capture.inst       = IInst;
        capture.rs_data    = IRsData;
        capture.rt_data    = IRtData;
        capture.imm_ext    = IImmExt;
        capture.reg_write  = IRegWrite;
        capture.mem_read   = IMemRead;
        capture.mem_write  = IMemWrite;
        capture.alu_src    = IALUSrc;
        capture.mem_to_reg = IMemToReg;
        capture.reg_dst    = IRegDst;
        capture.alu_op     = IALUOp;
        capture.write_reg  = dest_reg(regdst_e'(IRegDst), IInst[20:16], IInst[15:11]);
    end

    // Pipeline register: flush > hold > stall bubble > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r <= '0;
        else if (CFlush)
            r <= '0;
        else if (CHold)
            r <= r;
        else if (bubble)
            r <= '0;
        else
            r <= capture;
    end

    // Bubble counter: counts stall-inserted bubbles only, saturating at BUBBLE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            OBubbleCnt <= '0;
        else if (!CFlush && bubble && (OBubbleCnt != BUBBLE_MAX))
            OBubbleCnt <= OBubbleCnt + 16'd1;
    end

    assign OPCAdd4   = r.pc_add4;
    assign OInst     = r.inst;
    assign ORsData   = r.rs_data;
    assign ORtData   = r.rt_data;
    assign OImmExt   = r.imm_ext;
    assign ORegWrite = r.reg_write;
    assign OMemRead  = r.mem_read;
    assign OMemWrite = r.mem_write;
    assign OALUSrc   = r.alu_src;
    assign OMemToReg = r.mem_to_reg;
    assign ORegDst   = r.reg_dst;
    assign OALUOp    = r.alu_op;
    assign OWriteReg = r.write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_id_ex_stage;

    localparam logic [15:0] SAT = 16'd40;

    localparam logic [31:0] ADD_RD8  = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] LW_RT8   = 32'h8C080000; // lw  $8,0($0)
    localparam logic [31:0] ADD_RS8  = 32'h01095020; // add $10,$8,$9
    localparam logic [31:0] ADD_RT8  = 32'h01285020; // add $10,$9,$8
    localparam logic [31:0] LW_RT0   = 32'h8C000000; // lw  $0,0($0)
    localparam logic [31:0] ADD_RS0  = 32'h00005020; // add $10,$0,$0

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IPCAdd4 = '0, IInst = '0, IRsData = '0, IRtData = '0, IImmExt = '0;
    logic        IRegWrite = 1'b0, IMemRead = 1'b0, IMemWrite = 1'b0, IALUSrc = 1'b0;
    logic [1:0]  IMemToReg = '0, IRegDst = '0;
    logic [3:0]  IALUOp = '0;
    logic        CFlush = 1'b0, CHold = 1'b0;
    logic [31:0] OPCAdd4, OInst, ORsData, ORtData, OImmExt;
    logic        ORegWrite, OMemRead, OMemWrite, OALUSrc;
    logic [1:0]  OMemToReg, ORegDst;
    logic [3:0]  OALUOp;
    logic [4:0]  OWriteReg;
    logic        OStall;
    logic [15:0] OBubbleCnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned seed  = 1;

    id_ex_stage #(.BUBBLE_MAX(SAT)) dut (
        .clk(clk), .reset(reset),
        .IPCAdd4(IPCAdd4), .IInst(IInst), .IRsData(IRsData), .IRtData(IRtData),
        .IImmExt(IImmExt), .IRegWrite(IRegWrite), .IMemRead(IMemRead),
        .IMemWrite(IMemWrite), .IALUSrc(IALUSrc), .IMemToReg(IMemToReg),
        .IRegDst(IRegDst), .IALUOp(IALUOp), .CFlush(CFlush), .CHold(CHold),
        .OPCAdd4(OPCAdd4), .OInst(OInst), .ORsData(ORsData), .ORtData(ORtData),
        .OImmExt(OImmExt), .ORegWrite(ORegWrite), .OMemRead(OMemRead),
        .OMemWrite(OMemWrite), .OALUSrc(OALUSrc), .OMemToReg(OMemToReg),
        .ORegDst(ORegDst), .OALUOp(OALUOp), .OWriteReg(OWriteReg),
        .OStall(OStall), .OBubbleCnt(OBubbleCnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_inst, m_rs, m_rt, m_imm;
    logic        m_rw, m_mr, m_mw, m_as;
    logic [1:0]  m_mtr, m_rd;
    logic [3:0]  m_op;
    logic [4:0]  m_wr;
    logic [15:0] m_cnt;
    logic        m_stall;

    // A load in EX whose nonzero target is read by the ID instruction stalls, unless flushed.
    assign m_stall = !CFlush && m_mr && (m_wr != 5'd0) &&
                     ((m_wr == IInst[25:21]) || (m_wr == IInst[20:16]));

    function automatic logic [4:0] pick_dest(input logic [1:0] sel, input logic [31:0] inst);
        if (sel == 2'd0) return inst[20:16];
        if (sel == 2'd1) return inst[15:11];
        if (sel == 2'd2) return 5'd31;
        return 5'd0;
    endfunction

    // Model update on each edge: zero on flush or unheld stall, keep on hold, else load.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {m_pc, m_inst, m_rs, m_rt, m_imm, m_rw, m_mr, m_mw, m_as, m_mtr, m_rd, m_op, m_wr} <= '0;
            m_cnt <= '0;
        end else if (CFlush || (!CHold && m_stall)) begin
            {m_pc, m_inst, m_rs, m_rt, m_imm, m_rw, m_mr, m_mw, m_as, m_mtr, m_rd, m_op, m_wr} <= '0;
            if (m_stall && m_cnt < SAT) m_cnt <= m_cnt + 16'd1;
        end else if (!CHold) begin
            m_pc <= IPCAdd4; m_inst <= IInst; m_rs <= IRsData; m_rt <= IRtData; m_imm <= IImmExt;
            m_rw <= IRegWrite; m_mr <= IMemRead; m_mw <= IMemWrite; m_as <= IALUSrc;
            m_mtr <= IMemToReg; m_rd <= IRegDst; m_op <= IALUOp;
            m_wr <= pick_dest(IRegDst, IInst);
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        check("outputs",
              {OPCAdd4, OInst, ORsData, ORtData, OImmExt, ORegWrite, OMemRead, OMemWrite,
               OALUSrc, OMemToReg, ORegDst, OALUOp, OWriteReg},
              {m_pc, m_inst, m_rs, m_rt, m_imm, m_rw, m_mr, m_mw, m_as, m_mtr, m_rd, m_op, m_wr});
        check("OStall", OStall, m_stall);
        check("OBubbleCnt", OBubbleCnt, m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [31:0] inst, input logic mr, input logic [1:0] rd);
        seed++;
        IInst     = inst;
        IPCAdd4   = seed * 4;
        IRsData   = seed ^ 32'hA5A5_0000;
        IRtData   = seed ^ 32'h0000_5A5A;
        IImmExt   = {16'h0, seed[15:0]};
        IMemRead  = mr;
        IRegDst   = rd;
        IRegWrite = 1'b1;
        IMemWrite = seed[0];
        IALUSrc   = mr;
        IMemToReg = {1'b0, mr};
        IALUOp    = seed[3:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;

        // Asynchronous reset mid-cycle with live nonzero inputs.
        drive(ADD_RD8, 1'b1, 2'd1);
        step();
        check("captured before reset", OInst, ADD_RD8);
        #2 reset = 1'b1;
        #1;
        check("reset OInst", OInst, 32'h0);
        check("reset OMemRead", OMemRead, 1'b0);
        check("reset OBubbleCnt", OBubbleCnt, 16'h0);
        reset = 1'b0;

        // Pass-through and destination select.
        drive(ADD_RD8, 1'b0, 2'd1);
        step();
        check("pass OInst", OInst, ADD_RD8);
        check("pass OWriteReg", OWriteReg, 5'd8);
        drive(ADD_RD8, 1'b0, 2'd2);
        step();
        check("regdst ra", OWriteReg, 5'd31);
        drive(ADD_RD8, 1'b0, 2'd3);
        step();
        check("regdst zero", OWriteReg, 5'd0);

        // Load-use: one bubble, then the dependent add.
        drive(LW_RT8, 1'b1, 2'd0);
        step();
        check("lw OWriteReg", OWriteReg, 5'd8);
        drive(ADD_RS8, 1'b0, 2'd1);
        #1 check("load-use stall", OStall, 1'b1);
        step();
        check("bubble OMemRead", OMemRead, 1'b0);
        check("bubble OInst", OInst, 32'h0);
        check("bubble count", OBubbleCnt, 16'd1);
        check("stall released", OStall, 1'b0);
        step();
        check("add after bubble", OInst, ADD_RS8);
        check("add OWriteReg", OWriteReg, 5'd10);

        // Flush overrides stall.
        drive(LW_RT8, 1'b1, 2'd0);
        step();
        drive(ADD_RT8, 1'b0, 2'd1);
        CFlush = 1'b1;
        #1 check("flush kills stall", OStall, 1'b0);
        step();
        check("flush OInst", OInst, 32'h0);
        check("flush count kept", OBubbleCnt, 16'd1);
        CFlush = 1'b0;

        // Hold freezes register with hazard pending.
        drive(LW_RT8, 1'b1, 2'd0);
        step();
        drive(ADD_RS8, 1'b0, 2'd1);
        CHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold stall", OStall, 1'b1);
            step();
            check("hold OInst", OInst, LW_RT8);
            drive(ADD_RS8, 1'b0, 2'd1);
        end
        check("hold count", OBubbleCnt, 16'd1);
        CHold = 1'b0;
        step();
        check("post-hold bubble count", OBubbleCnt, 16'd2);
        step();
        check("post-hold add", OInst, ADD_RS8);

        // Load to $0 never stalls.
        drive(LW_RT0, 1'b1, 2'd0);
        step();
        drive(ADD_RS0, 1'b0, 2'd1);
        #1 check("lw $0 no stall", OStall, 1'b0);
        step();
        check("lw $0 next OInst", OInst, ADD_RS0);

        // Reset during a pending stall.
        drive(LW_RT8, 1'b1, 2'd0);
        step();
        drive(ADD_RS8, 1'b0, 2'd1);
        #1 check("pre-reset stall", OStall, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("reset drops stall", OStall, 1'b0);
        check("reset clears count", OBubbleCnt, 16'h0);
        reset = 1'b0;
        step();
        check("capture after reset", OInst, ADD_RS8);

        // Saturation of the bubble counter.
        for (int i = 0; i < int'(SAT) + 3; i++) begin
            drive(LW_RT8, 1'b1, 2'd0);
            step();
            drive(i[0] ? ADD_RT8 : ADD_RS8, 1'b0, 2'd1);
            step();
        end
        check("saturated count", OBubbleCnt, SAT);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
